// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - ALU operand select with forwarding and a two-entry skid buffer.
// Operands are resolved at accept time; buffered entries are never re-forwarded.
module operand_stage #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 30,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              sel_a,
  input  logic [2:0]              sel_b,
  input  logic [XLEN-1:0]         upper_imm,
  input  logic [XLEN-1:0]         j_imm,
  input  logic [XLEN-1:0]         b_imm,
  input  logic [XLEN-1:0]         lower_imm,
  input  logic [XLEN-1:0]         s_imm,
  input  logic [PC_W-1:0]         pc_in,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         reg_a,
  input  logic [XLEN-1:0]         reg_b,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         op_a,
  output logic [XLEN-1:0]         op_b
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic [XLEN-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
  logic [XLEN-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  logic [XLEN-1:0] res_a, res_b, new_a, new_b;
  logic            accept, drain;

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    res_a = reg_a;
    res_b = reg_b;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == rs1_addr && rs1_addr != 5'd0)
        res_a = fwd_data[XLEN*i +: XLEN];
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == rs2_addr && rs2_addr != 5'd0)
        res_b = fwd_data[XLEN*i +: XLEN];
    end
  end

  always_comb begin
    new_a = '0;
    case (sel_a)
      2'd0:    new_a = upper_imm;
      2'd1:    new_a = j_imm;
      2'd2:    new_a = b_imm;
      default: new_a = res_a;
    endcase
    new_b = '0;
    case (sel_b)
      3'd0:    new_b = lower_imm;
      3'd1:    new_b = s_imm;
      3'd2:    new_b = XLEN'(pc_in);
      3'd3:    new_b = XLEN'(rs2_addr);
      3'd4:    new_b = res_b;
      default: new_b = '0;
    endcase
  end

  assign in_ready  = clk_enable & rdy_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign op_a      = main_a_q;
  assign op_b      = main_b_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready & clk_enable;

  always_comb begin
    state_d  = state_q;
    rdy_d    = rdy_q;
    main_a_d = main_a_q;
    main_b_d = main_b_q;
    skid_a_d = skid_a_q;
    skid_b_d = skid_b_q;
    if (clk_enable) begin
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d  = ST_ONE;
              main_a_d = new_a;
              main_b_d = new_b;
            end
          end
          ST_ONE: begin
            if (accept && drain) begin
              main_a_d = new_a;
              main_b_d = new_b;
            end else if (accept) begin
              state_d  = ST_FULL;
              skid_a_d = new_a;
              skid_b_d = new_b;
            end else if (drain) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (drain) begin
              state_d  = ST_ONE;
              main_a_d = skid_a_q;
              main_b_d = skid_b_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      rdy_d = (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rdy_q    <= 1'b0;
      main_a_q <= '0;
      main_b_q <= '0;
      skid_a_q <= '0;
      skid_b_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      main_a_q <= main_a_d;
      main_b_q <= main_b_d;
      skid_a_q <= skid_a_d;
      skid_b_q <= skid_b_d;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed vector bench for operand_stage.
module tb_operand_stage;
  localparam int XLEN = 32;
  localparam int PC_W = 30;
  localparam int NF   = 2;

  logic            clk = 1'b0;
  logic            rst_n, clk_enable, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      sel_a;
  logic [2:0]      sel_b;
  logic [XLEN-1:0] upper_imm, j_imm, b_imm, lower_imm, s_imm, reg_a, reg_b, op_a, op_b;
  logic [PC_W-1:0] pc_in;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [NF-1:0]   fwd_valid;
  logic [NF*5-1:0] fwd_addr;
  logic [NF*XLEN-1:0] fwd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_stage #(.XLEN(XLEN), .PC_W(PC_W), .NUM_FWD(NF)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .sel_a(sel_a), .sel_b(sel_b),
    .upper_imm(upper_imm), .j_imm(j_imm), .b_imm(b_imm), .lower_imm(lower_imm),
    .s_imm(s_imm), .pc_in(pc_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .reg_a(reg_a), .reg_b(reg_b), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b)
  );

  typedef struct {
    logic [1:0]  sa;
    logic [2:0]  sb;
    logic [31:0] up, jj, bb, lo, ss;
    logic [29:0] pc;
    logic [4:0]  r1, r2;
    logic [31:0] ra, rb;
    logic [1:0]  fv;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;
    logic [31:0] ea, eb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sel_a = 0; sel_b = 0; upper_imm = 0; j_imm = 0; b_imm = 0; lower_imm = 0;
    s_imm = 0; pc_in = 0; rs1_addr = 0; rs2_addr = 0; reg_a = 0; reg_b = 0;
    fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    sel_a = v.sa; sel_b = v.sb; upper_imm = v.up; j_imm = v.jj; b_imm = v.bb;
    lower_imm = v.lo; s_imm = v.ss; pc_in = v.pc; rs1_addr = v.r1; rs2_addr = v.r2;
    reg_a = v.ra; reg_b = v.rb; fwd_valid = v.fv; fwd_addr = {v.fa1, v.fa0};
    fwd_data = {v.fd1, v.fd0};
  endtask

  // Immediate-only beat: op_a = a via upper_imm, op_b = b via lower_imm.
  task automatic drive_imm(input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    upper_imm = a;
    lower_imm = b;
  endtask

  function automatic vec_t mk(input logic [1:0] sa, input logic [2:0] sb);
    vec_t v;
    v.sa = sa; v.sb = sb; v.up = 0; v.jj = 0; v.bb = 0; v.lo = 0; v.ss = 0; v.pc = 0;
    v.r1 = 0; v.r2 = 0; v.ra = 0; v.rb = 0; v.fv = 0; v.fa0 = 0; v.fa1 = 0;
    v.fd0 = 0; v.fd1 = 0; v.ea = 0; v.eb = 0;
    return v;
  endfunction

  initial begin
    rst_n = 0; clk_enable = 1; flush = 0; in_valid = 1; out_ready = 0;
    clear_inputs();

    vecs[0] = mk(0, 0); vecs[0].up = 32'h12345000; vecs[0].lo = 32'h7FF;
    vecs[0].ea = 32'h12345000; vecs[0].eb = 32'h7FF;
    vecs[1] = mk(1, 2); vecs[1].jj = 32'hFFFFF800; vecs[1].pc = 30'h3FFFFFFF;
    vecs[1].ea = 32'hFFFFF800; vecs[1].eb = 32'h3FFFFFFF;
    vecs[2] = mk(2, 3); vecs[2].bb = 32'hFFFFFFFE; vecs[2].r2 = 5'd17;
    vecs[2].ea = 32'hFFFFFFFE; vecs[2].eb = 32'd17;
    vecs[3] = mk(3, 6); vecs[3].r1 = 5; vecs[3].ra = 1; vecs[3].fv = 2'b11;
    vecs[3].fa0 = 5; vecs[3].fa1 = 5; vecs[3].fd0 = 32'hAA; vecs[3].fd1 = 32'hBB;
    vecs[3].lo = 32'h1234; vecs[3].ea = 32'hAA; vecs[3].eb = 0;
    vecs[4] = mk(3, 1); vecs[4].r1 = 0; vecs[4].ra = 32'h55; vecs[4].fv = 2'b01;
    vecs[4].fa0 = 0; vecs[4].fd0 = 32'hEE; vecs[4].ss = 32'hABC;
    vecs[4].ea = 32'h55; vecs[4].eb = 32'hABC;
    vecs[5] = mk(3, 4); vecs[5].r1 = 5; vecs[5].r2 = 9; vecs[5].ra = 1; vecs[5].rb = 32'h99;
    vecs[5].fv = 2'b10; vecs[5].fa0 = 9; vecs[5].fa1 = 5; vecs[5].fd0 = 32'hCC;
    vecs[5].fd1 = 32'hBB; vecs[5].ea = 32'hBB; vecs[5].eb = 32'h99;
    vecs[6] = vecs[5]; vecs[6].fv = 2'b11; vecs[6].fd0 = 32'hCC; vecs[6].fd1 = 32'hDD;
    vecs[6].ea = 32'hDD; vecs[6].eb = 32'hCC;
    vecs[7] = mk(3, 7); vecs[7].r1 = 3; vecs[7].ra = 32'h33; vecs[7].lo = 32'h77;
    vecs[7].ea = 32'h33; vecs[7].eb = 0;

    // Reset with in_valid held high
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1; in_valid = 0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_out_valid", 32'(out_valid), 0);

    // Back-to-back vectors with out_ready high: one beat per cycle
    out_ready = 1;
    in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      drive_vec(vecs[k]);
      tick();
      check($sformatf("vec%0d_valid", k), 32'(out_valid), 1);
      check($sformatf("vec%0d_op_a", k), op_a, vecs[k].ea);
      check($sformatf("vec%0d_op_b", k), op_b, vecs[k].eb);
      check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 1);
    end
    in_valid = 0;
    tick();
    check("drain_empty", 32'(out_valid), 0);

    // Backpressure: X, Y buffered, Z refused, then drained in order
    out_ready = 0; in_valid = 1;
    drive_imm(32'h1111, 32'hA1);
    tick();
    check("bp_x_a", op_a, 32'h1111);
    check("bp_one_ready", 32'(in_ready), 1);
    drive_imm(32'h2222, 32'hA2);
    tick();
    check("bp_full_ready", 32'(in_ready), 0);
    check("bp_hold_x_a", op_a, 32'h1111);
    drive_imm(32'h3333, 32'hA3);
    tick();
    check("bp_hold2_x_b", op_b, 32'hA1);
    in_valid = 0; out_ready = 1;
    tick();
    check("bp_y_valid", 32'(out_valid), 1);
    check("bp_y_a", op_a, 32'h2222);
    check("bp_y_b", op_b, 32'hA2);
    check("bp_y_ready", 32'(in_ready), 1);
    tick();
    check("bp_end_empty", 32'(out_valid), 0);

    // Flush while FULL with a beat offered
    out_ready = 0; in_valid = 1;
    drive_imm(32'h4444, 0); tick();
    drive_imm(32'h5555, 0); tick();
    check("fl_full_ready", 32'(in_ready), 0);
    flush = 1;
    drive_imm(32'h6666, 0);
    tick();
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_in_ready", 32'(in_ready), 1);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    check("fl_no_ghost", 32'(out_valid), 0);

    // Flush with accept from EMPTY discards the beat too
    in_valid = 1; flush = 1;
    drive_imm(32'h6767, 0);
    tick();
    check("fl_empty_accept", 32'(out_valid), 0);
    flush = 0; in_valid = 0;

    // clk_enable low freezes the stage in ONE
    out_ready = 0; in_valid = 1;
    drive_imm(32'h7777, 32'h88);
    tick();
    check("ce_loaded", op_a, 32'h7777);
    in_valid = 0; out_ready = 1; clk_enable = 0;
    #1;
    check("ce_ready_low", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ce%0d_valid", k), 32'(out_valid), 1);
      check($sformatf("ce%0d_op_a", k), op_a, 32'h7777);
      check($sformatf("ce%0d_op_b", k), op_b, 32'h88);
      check($sformatf("ce%0d_ready", k), 32'(in_ready), 0);
    end
    clk_enable = 1;
    tick();
    check("ce_resume_drain", 32'(out_valid), 0);
    check("ce_resume_ready", 32'(in_ready), 1);

    // Asynchronous reset mid-operation
    out_ready = 0; in_valid = 1;
    drive_imm(32'h9999, 32'h1); tick();
    drive_imm(32'hAAAA, 32'h2); tick();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_op_a", op_a, 0);
    tick();
    rst_n = 1; out_ready = 1;
    tick(); tick();
    check("arst_after_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/operand_stage.md
# operand_stage

Parametrised operand-select stage between register read and the ALU. Per instruction it picks ALU operand A and operand B from immediates, PC, a zero-extended shift amount or register-file data, applies operand forwarding from up to NUM_FWD later pipeline stages, and registers the result. A valid/ready handshake with a two-entry skid buffer lets the ALU stall without losing operands, and a flush input squashes buffered work.

## Interface
Parameters:
- XLEN, 32, data width of operands and immediates
- PC_W, 30, width of pc_in (word-address PC)
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has highest priority

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clk_enable  in  1  global stall; low freezes all state
- flush  in  1  synchronous squash of all buffered entries
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- sel_a  in  2  0 upper_imm, 1 j_imm, 2 b_imm, 3 register A
- sel_b  in  3  0 lower_imm, 1 s_imm, 2 PC, 3 rs2 index, 4 register B, 5-7 reserved
- upper_imm, j_imm, b_imm, lower_imm, s_imm  in  XLEN each  pre-decoded immediates
- pc_in  in  PC_W  PC, zero-extended to XLEN
- rs1_addr, rs2_addr  in  5 each  source register indices
- reg_a, reg_b  in  XLEN each  register-file read data
- fwd_valid  in  NUM_FWD  forwarding source valid
- fwd_addr  in  NUM_FWD*5  destination index per source, packed, source i in bits [5i+4:5i]
- fwd_data  in  NUM_FWD*XLEN  result per source, packed likewise
- out_valid  out  1  operands valid
- out_ready  in  1  ALU accepts operands
- op_a, op_b  out  XLEN each  selected operands

## Operation
- Operand A mux: by sel_a. Value 3 uses resolved register A.
- Operand B mux: by sel_b. PC: pc_in zero-extended. rs2 index: rs2_addr zero-extended. 4: resolved register B. Reserved codes 5-7 produce 0.
- Forwarding (register A shown; B identical with rs2_addr/reg_b): candidate i matches when fwd_valid[i] and fwd_addr[i] == rs1_addr and rs1_addr != 0. Resolved value = fwd_data of lowest matching i; else reg_a. Address 0 never forwards; reg_a passed unchanged.
- Forwarding is sampled only in the accept cycle; buffered entries are not re-forwarded.
- Storage: main register (drives op_a/op_b/out_valid) plus skid register. States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
- in_ready = clk_enable & (state != FULL). Registered, derived from state only; no combinational path from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready & clk_enable.
- EMPTY: accept -> ONE, beat into main.
- ONE: accept & drain -> ONE, beat into main; accept only -> FULL, beat into skid; drain only -> EMPTY.
- FULL: drain -> ONE, skid moves to main; otherwise hold.
- Order preserved: skid always older-second, never overtakes main.
- flush (with clk_enable high): next state EMPTY, any simultaneous accept discarded, out_valid low next cycle. Data registers need not clear.
- clk_enable low: no state, data or flush takes effect; out_valid/op_a/op_b held; in_ready low.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, out_valid 0, op_a 0, op_b 0, skid data 0; in_ready 0 while rst_n low, 1 from first cycle after release with clk_enable high.
- Latency: beat accepted in cycle N appears on op_a/op_b with out_valid in cycle N+1.
- Throughput: one beat per cycle when out_ready held high.
- op_a/op_b stable while out_valid & !out_ready.
- Reset asserted mid-operation drops all entries immediately; no partial beat appears after release.

## Test plan
- Reset: rst_n low with in_valid high -> out_valid 0, op_a/op_b 0, in_ready 0; release -> in_ready 1 next cycle.
- Mux sweep: sel_b=2, pc_in=30'h3FFFFFFF -> op_b=32'h3FFFFFFF; sel_b=3, rs2_addr=5'd17 -> op_b=32'd17; sel_b=6 -> op_b=0; sel_a=1, j_imm=32'hFFFFF800 -> op_a=32'hFFFFF800, one cycle after accept.
- Forwarding priority: sel_a=3, rs1_addr=5, reg_a=1, fwd 0 and 1 both addr 5 with data 0xAA/0xBB -> op_a=0xAA; rs1_addr=0 with matching fwd addr 0 -> op_a=reg_a.
- Backpressure: out_ready low, accept beats X,Y -> in_ready 0 after Y; raise out_ready -> X then Y on consecutive cycles, none lost or reordered.
- Flush in FULL with in_valid high -> next cycle out_valid 0, in_ready 1, flushed-cycle beat never appears.
- clk_enable low for 3 cycles in ONE with out_ready high -> op_a/op_b/out_valid unchanged, in_ready 0; resumes draining when clk_enable returns high.
